hazard_scoreboard: RTL and testbench

Tracks in-flight register writes between decode issue and writeback for the scalar RF (16 regs), the vector RF (64 regs) and the condition code. Each destination has a small pending-write counter. Decode presents an instruction's sources and destinations; the block returns a dependency stall, or accepts the issue and marks its destinations busy. Writeback retire strobes release destinations. This block replaces the per-opcode ED/MD index comparisons in decode with one central scheduler.

---
 rtl/hazard_scoreboard.sv | 163 ++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Central RAW/WAW scoreboard: per-register pending-write counters for the scalar RF,
// vector RF and condition code, with issue gating and writeback release.
module hazard_scoreboard #(
    parameter int NUM_RF         = 16,
    parameter int NUM_VRF        = 64,
    parameter int VREG_ID_WIDTH  = 6,
    parameter int CNT_WIDTH      = 2,
    parameter int INFLIGHT_WIDTH = 8
) (
    input  logic                      I_CLOCK,
    input  logic                      I_RESET,
    input  logic                      I_LOCK,
    input  logic                      I_IssueValid,
    input  logic [3:0]                I_Src1Idx,
    input  logic [3:0]                I_Src2Idx,
    input  logic                      I_Src1Use,
    input  logic                      I_Src2Use,
    input  logic [VREG_ID_WIDTH-1:0]  I_VSrc1Idx,
    input  logic [VREG_ID_WIDTH-1:0]  I_VSrc2Idx,
    input  logic                      I_VSrc1Use,
    input  logic                      I_VSrc2Use,
    input  logic                      I_CCUse,
    input  logic [3:0]                I_DestIdx,
    input  logic                      I_DestWrite,
    input  logic [VREG_ID_WIDTH-1:0]  I_VDestIdx,
    input  logic                      I_VDestWrite,
    input  logic                      I_CCWrite,
    input  logic [3:0]                I_RetRegIdx,
    input  logic                      I_RetRegEn,
    input  logic [VREG_ID_WIDTH-1:0]  I_RetVRegIdx,
    input  logic                      I_RetVRegEn,
    input  logic                      I_RetCCEn,
    output logic                      O_DepStall,
    output logic                      O_SatStall,
    output logic                      O_IssueAccept,
    output logic [INFLIGHT_WIDTH-1:0] O_InFlight,
    output logic                      O_Idle,
    output logic                      O_Error
);

    localparam int                   RF_ID_WIDTH = 4;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0]      rf_cnt_reg  [NUM_RF];
    logic [CNT_WIDTH-1:0]      vrf_cnt_reg [NUM_VRF];
    logic [CNT_WIDTH-1:0]      cc_cnt_reg;
    logic [INFLIGHT_WIDTH-1:0] inflight_reg;
    logic [INFLIGHT_WIDTH-1:0] inflight_next;
    logic                      idle_reg;
    logic                      error_reg;

    logic src1_busy, src2_busy, vsrc1_busy, vsrc2_busy, cc_busy;
    logic dest_sat, vdest_sat, cc_sat;
    logic dep_stall, sat_stall, issue_accept;
    logic rf_ret_valid, vrf_ret_valid, cc_ret_valid;
    logic rf_underflow, vrf_underflow, cc_underflow;
    logic [1:0] inc_total, dec_total;

    // A pending count of exactly one that retires this cycle is already visible to the reader.
    function automatic logic src_busy(input logic [CNT_WIDTH-1:0] cnt, input logic ret_hit);
        return (cnt != '0) && !((cnt == CNT_ONE) && ret_hit);
    endfunction

    always_comb begin
        src1_busy  = I_Src1Use  && src_busy(rf_cnt_reg[I_Src1Idx], I_RetRegEn && (I_RetRegIdx == I_Src1Idx));
        src2_busy  = I_Src2Use  && src_busy(rf_cnt_reg[I_Src2Idx], I_RetRegEn && (I_RetRegIdx == I_Src2Idx));
        vsrc1_busy = I_VSrc1Use && src_busy(vrf_cnt_reg[I_VSrc1Idx], I_RetVRegEn && (I_RetVRegIdx == I_VSrc1Idx));
        vsrc2_busy = I_VSrc2Use && src_busy(vrf_cnt_reg[I_VSrc2Idx], I_RetVRegEn && (I_RetVRegIdx == I_VSrc2Idx));
        cc_busy    = I_CCUse    && src_busy(cc_cnt_reg, I_RetCCEn);

        dest_sat  = I_DestWrite  && (rf_cnt_reg[I_DestIdx] == CNT_MAX)
                    && !(I_RetRegEn && (I_RetRegIdx == I_DestIdx));
        vdest_sat = I_VDestWrite && (vrf_cnt_reg[I_VDestIdx] == CNT_MAX)
                    && !(I_RetVRegEn && (I_RetVRegIdx == I_VDestIdx));
        cc_sat    = I_CCWrite    && (cc_cnt_reg == CNT_MAX) && !I_RetCCEn;

        dep_stall    = I_IssueValid && (src1_busy || src2_busy || vsrc1_busy || vsrc2_busy || cc_busy);
        sat_stall    = I_IssueValid && (dest_sat || vdest_sat || cc_sat);
        issue_accept = I_IssueValid && I_LOCK && !dep_stall && !sat_stall;
    end

    // Retires against an empty counter are dropped and flagged rather than wrapping.
    always_comb begin
        rf_ret_valid  = I_RetRegEn  && (rf_cnt_reg[I_RetRegIdx] != '0);
        vrf_ret_valid = I_RetVRegEn && (vrf_cnt_reg[I_RetVRegIdx] != '0);
        cc_ret_valid  = I_RetCCEn   && (cc_cnt_reg != '0);
        rf_underflow  = I_RetRegEn  && !rf_ret_valid;
        vrf_underflow = I_RetVRegEn && !vrf_ret_valid;
        cc_underflow  = I_RetCCEn   && !cc_ret_valid;

        inc_total = {1'b0, issue_accept && I_DestWrite} + {1'b0, issue_accept && I_VDestWrite}
                  + {1'b0, issue_accept && I_CCWrite};
        dec_total = {1'b0, rf_ret_valid} + {1'b0, vrf_ret_valid} + {1'b0, cc_ret_valid};
        inflight_next = inflight_reg + INFLIGHT_WIDTH'(inc_total) - INFLIGHT_WIDTH'(dec_total);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RF; gi++) begin : g_rf_cnt
            logic inc, dec;
            assign inc = issue_accept && I_DestWrite && (I_DestIdx == RF_ID_WIDTH'(gi));
            assign dec = rf_ret_valid && (I_RetRegIdx == RF_ID_WIDTH'(gi));
            always_ff @(posedge I_CLOCK or posedge I_RESET) begin
                if (I_RESET) begin
                    rf_cnt_reg[gi] <= '0;
                end else if (I_LOCK) begin
                    if (inc && !dec) begin
                        rf_cnt_reg[gi] <= rf_cnt_reg[gi] + CNT_ONE;
                    end else if (dec && !inc) begin
                        rf_cnt_reg[gi] <= rf_cnt_reg[gi] - CNT_ONE;
                    end
                end
            end
        end

        for (gi = 0; gi < NUM_VRF; gi++) begin : g_vrf_cnt
            logic inc, dec;
            assign inc = issue_accept && I_VDestWrite && (I_VDestIdx == VREG_ID_WIDTH'(gi));
            assign dec = vrf_ret_valid && (I_RetVRegIdx == VREG_ID_WIDTH'(gi));
            always_ff @(posedge I_CLOCK or posedge I_RESET) begin
                if (I_RESET) begin
                    vrf_cnt_reg[gi] <= '0;
                end else if (I_LOCK) begin
                    if (inc && !dec) begin
                        vrf_cnt_reg[gi] <= vrf_cnt_reg[gi] + CNT_ONE;
                    end else if (dec && !inc) begin
                        vrf_cnt_reg[gi] <= vrf_cnt_reg[gi] - CNT_ONE;
                    end
                end
            end
        end
    endgenerate

    logic cc_inc;
    assign cc_inc = issue_accept && I_CCWrite;

    always_ff @(posedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            cc_cnt_reg   <= '0;
            inflight_reg <= '0;
            idle_reg     <= 1'b1;
            error_reg    <= 1'b0;
        end else if (I_LOCK) begin
            if (cc_inc && !cc_ret_valid) begin
                cc_cnt_reg <= cc_cnt_reg + CNT_ONE;
            end else if (cc_ret_valid && !cc_inc) begin
                cc_cnt_reg <= cc_cnt_reg - CNT_ONE;
            end
            inflight_reg <= inflight_next;
            idle_reg     <= (inflight_next == '0);
            error_reg    <= error_reg || rf_underflow || vrf_underflow || cc_underflow;
        end
    end

    assign O_DepStall    = dep_stall;
    assign O_SatStall    = sat_stall;
    assign O_IssueAccept = issue_accept;
    assign O_InFlight    = inflight_reg;
    assign O_Idle        = idle_reg;
    assign O_Error       = error_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: hand-computed expectations for stalls, accepts,
// in-flight count, idle and sticky error across issue/retire scenarios.
module tb_hazard_scoreboard;

    logic       I_CLOCK, I_RESET, I_LOCK, I_IssueValid;
    logic [3:0] I_Src1Idx, I_Src2Idx, I_DestIdx, I_RetRegIdx;
    logic       I_Src1Use, I_Src2Use, I_DestWrite, I_RetRegEn;
    logic [5:0] I_VSrc1Idx, I_VSrc2Idx, I_VDestIdx, I_RetVRegIdx;
    logic       I_VSrc1Use, I_VSrc2Use, I_VDestWrite, I_RetVRegEn;
    logic       I_CCUse, I_CCWrite, I_RetCCEn;
    logic       O_DepStall, O_SatStall, O_IssueAccept, O_Idle, O_Error;
    logic [7:0] O_InFlight;

    int tests_run = 0;
    int tests_failed = 0;

    hazard_scoreboard dut (
        .I_CLOCK(I_CLOCK), .I_RESET(I_RESET), .I_LOCK(I_LOCK), .I_IssueValid(I_IssueValid),
        .I_Src1Idx(I_Src1Idx), .I_Src2Idx(I_Src2Idx), .I_Src1Use(I_Src1Use), .I_Src2Use(I_Src2Use),
        .I_VSrc1Idx(I_VSrc1Idx), .I_VSrc2Idx(I_VSrc2Idx), .I_VSrc1Use(I_VSrc1Use), .I_VSrc2Use(I_VSrc2Use),
        .I_CCUse(I_CCUse), .I_DestIdx(I_DestIdx), .I_DestWrite(I_DestWrite),
        .I_VDestIdx(I_VDestIdx), .I_VDestWrite(I_VDestWrite), .I_CCWrite(I_CCWrite),
        .I_RetRegIdx(I_RetRegIdx), .I_RetRegEn(I_RetRegEn), .I_RetVRegIdx(I_RetVRegIdx),
        .I_RetVRegEn(I_RetVRegEn), .I_RetCCEn(I_RetCCEn),
        .O_DepStall(O_DepStall), .O_SatStall(O_SatStall), .O_IssueAccept(O_IssueAccept),
        .O_InFlight(O_InFlight), .O_Idle(O_Idle), .O_Error(O_Error)
    );

    initial I_CLOCK = 1'b0;
    always #5 I_CLOCK = ~I_CLOCK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic clear_inputs();
        I_LOCK = 1'b1; I_IssueValid = 1'b0;
        I_Src1Idx = '0; I_Src2Idx = '0; I_Src1Use = 1'b0; I_Src2Use = 1'b0;
        I_VSrc1Idx = '0; I_VSrc2Idx = '0; I_VSrc1Use = 1'b0; I_VSrc2Use = 1'b0;
        I_CCUse = 1'b0; I_DestIdx = '0; I_DestWrite = 1'b0;
        I_VDestIdx = '0; I_VDestWrite = 1'b0; I_CCWrite = 1'b0;
        I_RetRegIdx = '0; I_RetRegEn = 1'b0; I_RetVRegIdx = '0; I_RetVRegEn = 1'b0; I_RetCCEn = 1'b0;
    endtask

    // Inputs are settled 1 time unit after an edge; combinational checks follow a further #1.
    task automatic tick();
        @(posedge I_CLOCK);
        #1;
    endtask

    task automatic issue_dest(input logic [3:0] idx);
        clear_inputs();
        I_IssueValid = 1'b1; I_DestWrite = 1'b1; I_DestIdx = idx;
        tick();
        clear_inputs();
    endtask

    task automatic retire_reg(input logic [3:0] idx);
        clear_inputs();
        I_RetRegEn = 1'b1; I_RetRegIdx = idx;
        tick();
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        I_RESET = 1'b1;
        tick(); tick();
        check("reset_inflight", 32'(O_InFlight), 0);
        check("reset_idle", 32'(O_Idle), 1);
        check("reset_error", 32'(O_Error), 0);
        I_RESET = 1'b0;
        tick();

        // ADD R3 <- R1, R2
        I_IssueValid = 1; I_Src1Use = 1; I_Src1Idx = 1; I_Src2Use = 1; I_Src2Idx = 2;
        I_DestWrite = 1; I_DestIdx = 3;
        #1;
        check("add_dep", 32'(O_DepStall), 0);
        check("add_accept", 32'(O_IssueAccept), 1);
        tick();
        clear_inputs();
        check("add_inflight", 32'(O_InFlight), 1);
        check("add_idle", 32'(O_Idle), 0);

        // Unused source matching R3 is ignored; used one stalls until same-cycle retire
        I_IssueValid = 1; I_Src2Idx = 3; I_Src2Use = 0;
        #1;
        check("unused_src_dep", 32'(O_DepStall), 0);
        I_Src1Use = 1; I_Src1Idx = 3;
        #1;
        check("raw_r3_dep", 32'(O_DepStall), 1);
        check("raw_r3_accept", 32'(O_IssueAccept), 0);
        I_RetRegEn = 1; I_RetRegIdx = 3;
        #1;
        check("raw_r3_ret_dep", 32'(O_DepStall), 0);
        check("raw_r3_ret_accept", 32'(O_IssueAccept), 1);
        tick();
        clear_inputs();
        check("raw_r3_inflight", 32'(O_InFlight), 0);
        check("raw_r3_idle", 32'(O_Idle), 1);

        // Saturate R5
        for (int i = 0; i < 3; i++) issue_dest(4'd5);
        check("sat_r5_inflight", 32'(O_InFlight), 3);
        I_IssueValid = 1; I_DestWrite = 1; I_DestIdx = 5;
        #1;
        check("sat_r5_stall", 32'(O_SatStall), 1);
        check("sat_r5_accept", 32'(O_IssueAccept), 0);
        I_RetRegEn = 1; I_RetRegIdx = 5;
        #1;
        check("sat_r5_ret_stall", 32'(O_SatStall), 0);
        check("sat_r5_ret_accept", 32'(O_IssueAccept), 1);
        tick();
        clear_inputs();
        check("sat_r5_ret_inflight", 32'(O_InFlight), 3);
        I_IssueValid = 1; I_DestWrite = 1; I_DestIdx = 5;
        #1;
        check("sat_r5_still_full", 32'(O_SatStall), 1);
        clear_inputs();
        for (int i = 2; i >= 0; i--) begin
            retire_reg(4'd5);
            check($sformatf("drain_r5_%0d", i), 32'(O_InFlight), 32'(i));
        end

        // R10 and V10 pending: spaces are independent
        I_IssueValid = 1; I_DestWrite = 1; I_DestIdx = 10; I_VDestWrite = 1; I_VDestIdx = 10;
        tick();
        clear_inputs();
        check("rv10_inflight", 32'(O_InFlight), 2);
        I_IssueValid = 1; I_Src1Use = 1; I_Src1Idx = 10;
        #1;
        check("r10_read_dep", 32'(O_DepStall), 1);
        clear_inputs();
        retire_reg(4'd10);
        check("r10_ret_inflight", 32'(O_InFlight), 1);
        I_IssueValid = 1; I_Src1Use = 1; I_Src1Idx = 10;
        #1;
        check("r10_read_after_ret", 32'(O_IssueAccept), 1);
        I_Src1Use = 0; I_VSrc1Use = 1; I_VSrc1Idx = 10;
        #1;
        check("v10_read_dep", 32'(O_DepStall), 1);
        clear_inputs();
        I_RetVRegEn = 1; I_RetVRegIdx = 10;
        tick();
        clear_inputs();
        check("v10_ret_inflight", 32'(O_InFlight), 0);

        // Underflow on R7, sticky error, async reset mid-cycle
        retire_reg(4'd7);
        check("uf_error", 32'(O_Error), 1);
        check("uf_inflight", 32'(O_InFlight), 0);
        issue_dest(4'd2);
        check("uf_error_sticky", 32'(O_Error), 1);
        check("uf_pending_r2", 32'(O_InFlight), 1);
        #2;
        I_RESET = 1'b1;
        #1;
        check("async_rst_inflight", 32'(O_InFlight), 0);
        check("async_rst_idle", 32'(O_Idle), 1);
        check("async_rst_error", 32'(O_Error), 0);
        I_RESET = 1'b0;
        tick();

        // Lock low freezes issue and retire
        issue_dest(4'd1);
        I_LOCK = 0; I_IssueValid = 1; I_DestWrite = 1; I_DestIdx = 2; I_RetRegEn = 1; I_RetRegIdx = 1;
        #1;
        check("lock_accept", 32'(O_IssueAccept), 0);
        I_RetRegEn = 0; I_Src1Use = 1; I_Src1Idx = 1;
        #1;
        check("lock_dep_visible", 32'(O_DepStall), 1);
        I_Src1Use = 0; I_RetRegEn = 1;
        tick();
        clear_inputs();
        check("lock_inflight", 32'(O_InFlight), 1);
        check("lock_error", 32'(O_Error), 0);
        retire_reg(4'd1);
        check("lock_drain", 32'(O_InFlight), 0);

        // CC: CMP then branch
        I_IssueValid = 1; I_CCWrite = 1;
        tick();
        clear_inputs();
        check("cmp_inflight", 32'(O_InFlight), 1);
        I_IssueValid = 1; I_CCUse = 1;
        #1;
        check("branch_dep", 32'(O_DepStall), 1);
        I_RetCCEn = 1;
        #1;
        check("branch_ret_accept", 32'(O_IssueAccept), 1);
        tick();
        clear_inputs();
        check("branch_inflight", 32'(O_InFlight), 0);

        // Self-read-write, same-index issue+retire, three-way simultaneous retire
        I_IssueValid = 1; I_Src1Use = 1; I_Src1Idx = 6; I_DestWrite = 1; I_DestIdx = 6;
        #1;
        check("self_rw_accept", 32'(O_IssueAccept), 1);
        tick();
        clear_inputs();
        I_IssueValid = 1; I_DestWrite = 1; I_DestIdx = 6; I_RetRegEn = 1; I_RetRegIdx = 6;
        tick();
        clear_inputs();
        check("same_idx_inflight", 32'(O_InFlight), 1);
        I_IssueValid = 1; I_VDestWrite = 1; I_VDestIdx = 63; I_CCWrite = 1;
        tick();
        clear_inputs();
        check("three_pending", 32'(O_InFlight), 3);
        I_RetRegEn = 1; I_RetRegIdx = 6; I_RetVRegEn = 1; I_RetVRegIdx = 63; I_RetCCEn = 1;
        tick();
        clear_inputs();
        check("three_retire_inflight", 32'(O_InFlight), 0);
        check("three_retire_idle", 32'(O_Idle), 1);
        check("three_retire_error", 32'(O_Error), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
